// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage: state encoding
// and the occupancy values reported for each state.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd1;
    localparam logic [1:0] OCC_SKID  = 2'd2;

    function automatic logic [1:0] occ_of(input state_e s);
        logic [1:0] occ;
        occ = OCC_EMPTY;
        unique case (s)
            EMPTY:   occ = OCC_EMPTY;
            FULL:    occ = OCC_FULL;
            SKID:    occ = OCC_SKID;
            default: occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_dffe.sv
// Enabled payload register with synchronous active-low reset to BUBBLE.
module pipe_dffe #(
    parameter int unsigned WIDTH = 64,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             clrn_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!clrn_i) begin
            data_q <= BUBBLE;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage with flush and registered ready.
// Define PIPE_SKID_STAGE_STATS_EN to add the saturating stall_cnt output.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy
`ifdef PIPE_SKID_STAGE_STATS_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    state_e           state_q;
    state_e           state_d;
    logic             valid_q;
    logic             valid_d;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic             main_en;
    logic             skid_en;
    logic             accept;
    logic             drain;

    // Ready depends only on registered state, never on out_ready.
    assign in_ready = clrn & (state_q != SKID);
    assign accept   = in_valid & in_ready;
    assign drain    = valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = in_data;
        main_en = 1'b0;
        skid_en = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        main_en = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        main_en = 1'b1;
                    end else if (accept) begin
                        state_d = SKID;
                        skid_en = 1'b1;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (drain) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        main_en = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        valid_d = (state_d != EMPTY);
        occ_d   = occ_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            occ_q   <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    pipe_dffe #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clk_i  (clk),
        .clrn_i (clrn),
        .en_i   (main_en),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_dffe #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_skid (
        .clk_i  (clk),
        .clrn_i (clrn),
        .en_i   (skid_en),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

    assign out_valid = valid_q;
    assign occupancy = occ_q;
    assign out_data  = valid_q ? main_q : BUBBLE;

`ifdef PIPE_SKID_STAGE_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Saturates instead of wrapping; flush deliberately does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboarded directed bench for pipe_skid_stage.
module tb_pipe_skid_stage;

    localparam int unsigned W = 64;
    localparam logic [W-1:0] BUB = 64'hBBBB_0000_0000_BBBB;

    logic         clk;
    logic         clrn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         flush;
    logic [1:0]   occupancy;
`ifdef PIPE_SKID_STAGE_STATS_EN
    logic [31:0]  stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb_q[$];

    pipe_skid_stage #(
        .WIDTH  (W),
        .BUBBLE (BUB)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef PIPE_SKID_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (clrn !== 1'b1) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got %h want none", out_data);
                end else begin
                    chk("sb_data", out_data, sb_q.pop_front());
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
            end
        end
    end

    task automatic step(input logic rn, input logic v,
                        input logic [W-1:0] d, input logic r,
                        input logic f);
        clrn      = rn;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic ov,
                           input logic ir, input logic [1:0] oc,
                           input logic [W-1:0] od);
        chk({nm, "_ov"}, W'(out_valid), W'(ov));
        chk({nm, "_ir"}, W'(in_ready), W'(ir));
        chk({nm, "_occ"}, W'(occupancy), W'(oc));
        chk({nm, "_od"}, out_data, od);
    endtask

    initial begin
        step(0, 1, 64'h55, 1, 0);
        step(0, 1, 64'h55, 1, 0);
        chk_out("rst", 0, 0, 2'd0, BUB);

        step(1, 1, 64'h1, 1, 0);
        chk_out("str1", 1, 1, 2'd1, 64'h1);
        step(1, 1, 64'h2, 1, 0);
        chk_out("str2", 1, 1, 2'd1, 64'h2);
        step(1, 1, 64'h3, 1, 0);
        chk_out("str3", 1, 1, 2'd1, 64'h3);
        step(1, 0, 64'h0, 1, 0);
        chk_out("str_end", 0, 1, 2'd0, BUB);

        step(1, 1, 64'hA, 0, 0);
        chk_out("bp_a", 1, 1, 2'd1, 64'hA);
        step(1, 1, 64'hB, 0, 0);
        chk_out("bp_skid", 1, 0, 2'd2, 64'hA);
        step(1, 1, 64'hC, 0, 0);
        chk_out("bp_hold", 1, 0, 2'd2, 64'hA);
        step(1, 1, 64'hC, 1, 0);
        chk_out("bp_b", 1, 1, 2'd1, 64'hB);
        step(1, 0, 64'h0, 1, 0);
        chk_out("bp_end", 0, 1, 2'd0, BUB);

        step(1, 1, 64'h11, 0, 0);
        step(1, 1, 64'h22, 0, 0);
        chk_out("fl_skid", 1, 0, 2'd2, 64'h11);
        step(1, 1, 64'h33, 0, 1);
        chk_out("fl_skid_out", 0, 1, 2'd0, BUB);
        step(1, 1, 64'h44, 0, 0);
        chk_out("fl_full", 1, 1, 2'd1, 64'h44);
        step(1, 1, 64'h55, 1, 1);
        chk_out("fl_acc", 0, 1, 2'd0, BUB);
        step(1, 0, 64'h0, 1, 0);
        chk_out("fl_quiet", 0, 1, 2'd0, BUB);

        step(1, 1, 64'h77, 0, 0);
        step(1, 1, 64'h88, 0, 0);
        chk_out("mr_skid", 1, 0, 2'd2, 64'h77);
        step(0, 1, 64'h99, 1, 1);
        chk_out("mr_rst", 0, 0, 2'd0, BUB);
        step(1, 0, 64'h0, 1, 0);
        chk_out("mr_rel", 0, 1, 2'd0, BUB);
`ifdef PIPE_SKID_STAGE_STATS_EN
        chk("st_zero", W'(stall_cnt), W'(32'd0));
`endif

        step(1, 1, 64'h66, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 64'h0, 0, 0);
        end
        chk_out("st_stall", 1, 1, 2'd1, 64'h66);
`ifdef PIPE_SKID_STAGE_STATS_EN
        chk("st_five", W'(stall_cnt), W'(32'd5));
`endif
        step(1, 0, 64'h0, 1, 1);
        chk_out("st_flush", 0, 1, 2'd0, BUB);
`ifdef PIPE_SKID_STAGE_STATS_EN
        chk("st_keep", W'(stall_cnt), W'(32'd5));
`endif
        step(0, 0, 64'h0, 1, 0);
`ifdef PIPE_SKID_STAGE_STATS_EN
        chk("st_clr", W'(stall_cnt), W'(32'd0));
`endif
        step(1, 0, 64'h0, 1, 0);
        step(1, 0, 64'h0, 1, 0);
        chk("sb_left", W'(sb_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL take parameter WIDTH, default 64, as the payload width in bits (default covers pc+4 and instruction).
REQ-002 The block SHALL take parameter BUBBLE, default {WIDTH{1'b0}}, as the payload value presented while no entry is valid.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clrn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream payload valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the stage can accept a payload this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: oldest held payload.
REQ-011 The block SHALL have port flush, input, 1 bit: discard all held and incoming entries.
REQ-012 The block SHALL have port occupancy, output, 2 bits: number of held entries (0, 1 or 2).

Function
REQ-013 The block SHALL implement states EMPTY (0 entries), FULL (main register valid), SKID (main and skid registers valid).
REQ-014 Accept = in_valid & in_ready; drain = out_valid & out_ready; both SHALL be evaluated on the same edge.
REQ-015 Transitions: EMPTY+accept->FULL; FULL+accept+drain->FULL (main<=in_data); FULL+accept,no drain->SKID (skid<=in_data); FULL+drain,no accept->EMPTY; SKID+drain->FULL (main<=skid); otherwise hold.
REQ-016 in_ready SHALL be 1 exactly when state!=SKID and clrn=1, with no combinational path from out_ready or in_valid.
REQ-017 out_valid SHALL equal (state!=EMPTY); out_data SHALL equal main when valid, BUBBLE when EMPTY.
REQ-018 Latency in_data->out_data SHALL be one cycle when not stalled; payload order SHALL be strictly FIFO with no loss or duplication.
REQ-019 flush=1 SHALL force next state EMPTY regardless of accept or drain; a payload accepted in the flush cycle SHALL be discarded.
REQ-020 Held registers SHALL not change when state holds (stall), so out_data is stable while out_valid=1 and out_ready=0.
REQ-021 occupancy SHALL equal 0/1/2 for EMPTY/FULL/SKID.

Reset
REQ-022 On a rising edge with clrn=0: state EMPTY, main and skid <= BUBBLE, out_valid=0, occupancy=0.
REQ-023 While clrn=0, in_ready SHALL be 0; reset SHALL override flush and any handshake, including mid-SKID.

Configuration
REQ-024 With macro PIPE_SKID_STAGE_STATS_EN defined, the block SHALL add output stall_cnt, 32 bits: cycles with out_valid=1 and out_ready=0, saturating at 32'hFFFF_FFFF, cleared by reset, not by flush.
REQ-025 Without PIPE_SKID_STAGE_STATS_EN, stall_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 A shared package pipe_pkg SHALL hold the state enum (EMPTY, FULL, SKID) and occupancy encoding constants.
REQ-027 One sub-module pipe_dffe (WIDTH-bit, sync active-low reset to BUBBLE, enable) SHALL be instantiated for main and skid registers.

Verification
REQ-028 Reset: clrn=0 two cycles, in_valid=1 -> out_valid=0, in_ready=0, out_data=BUBBLE, occupancy=0.
REQ-029 Streaming: out_ready=1, in_data=1,2,3 back-to-back -> out_data 1,2,3 on next three cycles, occupancy=1, in_ready=1 throughout.
REQ-030 Backpressure: out_ready=0, feed 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA stable; out_ready=1 -> 0xA then 0xB, no 0xC accepted while in_ready=0.
REQ-031 Flush: SKID state plus in_valid=1 with flush=1 -> next cycle EMPTY, out_valid=0, out_data=BUBBLE, in_ready=1.
REQ-032 Reset mid-SKID: clrn=0 one edge -> all outputs at reset values, no stale payload emitted after release.
REQ-033 Stats (macro defined): out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; flush leaves it 5; reset clears to 0.
